// File: rtl/date_loader.sv
// date_loader: steps a calendar date counter through its up/set edit port until
// its packed date_count equals a latched target date.
//   clock, reset          : system clock, synchronous active-high reset
//   start                 : one-cycle load request, honoured only when idle
//   target_year/month/day : requested date (binary year, month 1..12, day 1..31)
//   date_count            : counter feedback {year[13:0], month[3:0], day[4:0]}
//   up                    : one-cycle increment pulses {thou, hund, tens, ones, month, day}
//   set                   : edit-mode enable to the counter, 2'b11 while loading
//   busy                  : load in progress
//   done, error           : one-cycle completion / failure pulses
module date_loader #(
    parameter int SETTLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] target_year,
    input  logic [3:0]  target_month,
    input  logic [4:0]  target_day,
    input  logic [22:0] date_count,
    output logic [5:0]  up,
    output logic [1:0]  set,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int WW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] W_LOAD = WW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SETUP, S_CMP, S_PULSE, S_WAIT, S_FINISH, S_ERROR
    } state_t;

    state_t        state;
    logic [13:0]   ty;
    logic [3:0]    tm;
    logic [4:0]    td;
    logic [2:0]    idx;
    logic [4:0]    pcnt;
    logic [WW-1:0] wcnt;

    logic [15:0] ty_bcd, cur_bcd;
    logic        leap, valid, match;
    logic [4:0]  last_day, cur_f, tgt_f, limit;

    // Double-dabble: four BCD digits of a binary year.
    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        logic [29:0] s;
        s = {16'd0, b};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++)
                if (s[14 + 4*d +: 4] > 4'd4) s[14 + 4*d +: 4] = s[14 + 4*d +: 4] + 4'd3;
            s = s << 1;
        end
        return s[29:14];
    endfunction

    always_comb begin
        ty_bcd   = to_bcd(ty);
        cur_bcd  = to_bcd(date_count[22:9]);
        leap     = (ty[1:0] == 2'd0 && (ty % 14'd100) != 14'd0) || (ty % 14'd400) == 14'd0;
        last_day = tm == 4'd2 ? (leap ? 5'd29 : 5'd28) :
                   (tm == 4'd4 || tm == 4'd6 || tm == 4'd9 || tm == 4'd11) ? 5'd30 : 5'd31;
        valid    = tm >= 4'd1 && tm <= 4'd12 && td >= 5'd1 && td <= last_day && ty <= 14'd9999;
        // Field order: thousands, hundreds, tens, ones, month, day.
        cur_f    = idx == 3'd0 ? {1'b0, cur_bcd[15:12]} :
                   idx == 3'd1 ? {1'b0, cur_bcd[11:8]}  :
                   idx == 3'd2 ? {1'b0, cur_bcd[7:4]}   :
                   idx == 3'd3 ? {1'b0, cur_bcd[3:0]}   :
                   idx == 3'd4 ? {1'b0, date_count[8:5]} : date_count[4:0];
        tgt_f    = idx == 3'd0 ? {1'b0, ty_bcd[15:12]} :
                   idx == 3'd1 ? {1'b0, ty_bcd[11:8]}  :
                   idx == 3'd2 ? {1'b0, ty_bcd[7:4]}   :
                   idx == 3'd3 ? {1'b0, ty_bcd[3:0]}   :
                   idx == 3'd4 ? {1'b0, tm} : td;
        limit    = idx < 3'd4 ? 5'd10 : idx == 3'd4 ? 5'd12 : 5'd31;
        match    = cur_f == tgt_f;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            ty    <= '0;
            tm    <= '0;
            td    <= '0;
            idx   <= '0;
            pcnt  <= '0;
            wcnt  <= '0;
            up    <= '0;
            set   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            up    <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    ty    <= target_year;
                    tm    <= target_month;
                    td    <= target_day;
                    busy  <= 1'b1;
                    state <= S_CHECK;
                end
                S_CHECK: if (valid) begin
                    set   <= 2'b11;
                    wcnt  <= W_LOAD;
                    state <= S_SETUP;
                end else begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_ERROR;
                end
                S_SETUP: if (wcnt == '0) begin
                    idx   <= '0;
                    pcnt  <= '0;
                    state <= S_CMP;
                end else wcnt <= wcnt - 1'b1;
                S_CMP: if (match) begin
                    idx  <= idx + 1'b1;
                    pcnt <= '0;
                    if (idx == 3'd5) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        set   <= '0;
                        state <= S_FINISH;
                    end
                end else if (pcnt == limit) begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    set   <= '0;
                    state <= S_ERROR;
                end else begin
                    // Field 0 (thousands) maps to up[5], field 5 (day) to up[0].
                    up    <= 6'b100000 >> idx;
                    state <= S_PULSE;
                end
                S_PULSE: begin
                    pcnt  <= pcnt + 1'b1;
                    wcnt  <= W_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: if (wcnt == '0) state <= S_CMP;
                        else wcnt <= wcnt - 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_date_loader.sv
// tb_date_loader: randomized and directed checks of date_loader driving a behavioural date counter.
module tb_date_loader;
    localparam int ST = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] target_year = '0;
    logic [3:0]  target_month = 4'd1;
    logic [4:0]  target_day = 5'd1;
    logic [22:0] date_count;
    logic [5:0]  up;
    logic [1:0]  set;
    logic        busy, done, error;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    date_loader #(.SETTLE(ST)) dut (
        .clock(clock), .reset(reset), .start(start),
        .target_year(target_year), .target_month(target_month), .target_day(target_day),
        .date_count(date_count), .up(up), .set(set),
        .busy(busy), .done(done), .error(error)
    );

    // Behavioural calendar counter
    int yr = 2024, mo = 1, dy = 1;
    bit ld = 1'b0, ign_m = 1'b0;
    int ld_y, ld_m, ld_d;
    assign date_count = {yr[13:0], mo[3:0], dy[4:0]};

    function automatic int mdays(input int m, input int y);
        bit lp;
        lp = (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
        return m == 2 ? (lp ? 29 : 28) : (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
    endfunction

    function automatic int pw10(input int p);
        return p == 0 ? 1 : p == 1 ? 10 : p == 2 ? 100 : 1000;
    endfunction

    function automatic int dig(input int y, input int p);
        return (y / pw10(p)) % 10;
    endfunction

    always @(posedge clock) begin
        if (ld) begin
            yr <= ld_y; mo <= ld_m; dy <= ld_d;
        end else if (set == 2'b11) begin
            if (up[0]) dy <= dy >= mdays(mo, yr) ? 1 : dy + 1;
            if (up[1] && !ign_m) mo <= mo == 12 ? 1 : mo + 1;
            for (int k = 2; k < 6; k++)
                if (up[k]) yr <= yr - dig(yr, k - 2) * pw10(k - 2) + ((dig(yr, k - 2) + 1) % 10) * pw10(k - 2);
        end
    end

    // Pulse counters and per-cycle rule checks
    int pc[6] = '{default: 0};
    int dn = 0, er = 0, viol = 0;
    always @(negedge clock) begin
        for (int k = 0; k < 6; k++) if (up[k]) pc[k]++;
        if (done) dn++;
        if (error) er++;
        if ($countones(up) > 1 || (done && error) || ((done || error) && busy) || (up != 0 && set != 2'b11)) viol++;
    end

    int base[6], dp[6];
    int bdn, ber;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic preset(input int y, input int m, input int d);
        @(negedge clock);
        ld_y = y; ld_m = m; ld_d = d; ld = 1'b1;
        @(negedge clock);
        ld = 1'b0;
    endtask

    // kind: 1 done, 2 error, 0 timed out; lat counts cycles from the start-sampling edge
    task automatic run(input string tag, input int y, input int m, input int d, input int alt_at,
                       output int lat, output int kind, output int set_first, output int busy1);
        int n;
        for (int k = 0; k < 6; k++) base[k] = pc[k];
        bdn = dn; ber = er;
        @(negedge clock);
        target_year = 14'(y); target_month = 4'(m); target_day = 5'(d); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1; busy1 = int'(busy); kind = 0; lat = 0; set_first = 0;
        while (n < 3000 && kind == 0) begin
            if (n == alt_at) begin
                target_year = 14'd1234; target_month = 4'd7; target_day = 5'd7; start = 1'b1;
            end else start = 1'b0;
            if (set == 2'b11 && set_first == 0) set_first = n;
            if (done) kind = 1;
            else if (error) kind = 2;
            if (kind != 0) lat = n;
            else begin
                @(negedge clock);
                n++;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, int'(kind != 0), 1);
        repeat (2) @(negedge clock);
        #1;
        for (int k = 0; k < 6; k++) dp[k] = pc[k] - base[k];
    endtask

    task automatic exp_pulses(input int cy, input int cm, input int cd,
                              input int ty, input int tm, input int td, output int e[6]);
        int l;
        for (int p = 0; p < 4; p++) e[2 + p] = ((dig(ty, p) - dig(cy, p)) % 10 + 10) % 10;
        e[1] = ((tm - cm) % 12 + 12) % 12;
        l = mdays(tm, ty);
        e[0] = cd <= td ? td - cd : (cd >= l ? td : l - cd + td);
    endtask

    task automatic load_check(input string tag, input int cy, input int cm, input int cd,
                              input int ty, input int tm, input int td, input int alt_at);
        int e[6];
        int lat, kind, sf, b1, p;
        preset(cy, cm, cd);
        exp_pulses(cy, cm, cd, ty, tm, td, e);
        run(tag, ty, tm, td, alt_at, lat, kind, sf, b1);
        p = 0;
        for (int k = 0; k < 6; k++) p += e[k];
        chk({tag, "_kind"}, kind, 1);
        chk({tag, "_busy1"}, b1, 1);
        chk({tag, "_set_first"}, sf, 2);
        chk({tag, "_latency"}, lat, ST + 8 + p * (2 + ST));
        for (int k = 0; k < 6; k++) chk($sformatf("%s_up%0d", tag, k), dp[k], e[k]);
        chk({tag, "_done_count"}, dn - bdn, 1);
        chk({tag, "_error_count"}, er - ber, 0);
        chk({tag, "_date"}, int'(date_count), (ty << 9) | (tm << 5) | td);
        chk({tag, "_set_after"}, int'(set), 0);
        chk({tag, "_rules"}, viol, 0);
    endtask

    task automatic bad_target(input string tag, input int y, input int m, input int d);
        int lat, kind, sf, b1, s;
        run(tag, y, m, d, 0, lat, kind, sf, b1);
        s = 0;
        for (int k = 0; k < 6; k++) s += dp[k];
        chk({tag, "_kind"}, kind, 2);
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_busy1"}, b1, 1);
        chk({tag, "_no_set"}, sf, 0);
        chk({tag, "_no_up"}, s, 0);
        chk({tag, "_done_count"}, dn - bdn, 0);
    endtask

    initial begin
        int cy, cm, cd, ty, tm, td, lat, kind, sf, b1, n;
        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_up", int'(up), 0);
        chk("reset_set", int'(set), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done_error", int'({done, error}), 0);

        // Directed loads
        load_check("simple", 2024, 1, 1, 2025, 3, 15, 0);
        chk("simple_up2_fixed", dp[2], 1);
        chk("simple_up1_fixed", dp[1], 2);
        chk("simple_up0_fixed", dp[0], 14);
        load_check("wrap", 2029, 12, 31, 2031, 1, 1, 0);
        chk("wrap_up3_fixed", dp[3], 1);
        chk("wrap_up2_fixed", dp[2], 2);
        load_check("equal", 2024, 6, 15, 2024, 6, 15, 0);
        load_check("leap2000", 2000, 1, 31, 2000, 2, 29, 0);

        // Invalid targets
        bad_target("leap2023", 2023, 2, 29);
        bad_target("leap1900", 1900, 2, 29);
        bad_target("month13", 2024, 13, 1);
        bad_target("month0", 2024, 0, 1);
        bad_target("day0", 2024, 1, 0);
        bad_target("apr31", 2024, 4, 31);
        bad_target("year10000", 10000, 1, 1);

        // Month field that never converges
        ign_m = 1'b1;
        preset(2024, 5, 10);
        run("noconv", 2024, 6, 10, 0, lat, kind, sf, b1);
        ign_m = 1'b0;
        chk("noconv_kind", kind, 2);
        chk("noconv_up1", dp[1], 12);
        chk("noconv_latency", lat, ST + 7 + 12 * (2 + ST));
        chk("noconv_set_after", int'(set), 0);
        chk("noconv_busy_after", int'(busy), 0);

        // Start while busy is ignored
        load_check("busy_start", 2024, 1, 1, 2025, 3, 15, 10);

        // Reset in the middle of a month pulse
        preset(2024, 1, 1);
        @(negedge clock);
        target_year = 14'd2024; target_month = 4'd5; target_day = 5'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!up[1] && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("midreset_saw_up1", int'(up[1]), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_up_cut", int'(up), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_outputs", int'({up, set, busy, done, error}), 0);
        repeat (3) @(negedge clock);
        chk("midreset_idle_quiet", int'({up, set, busy}), 0);
        load_check("after_reset", 2024, 2, 1, 2024, 3, 15, 0);

        // Randomized loads against the arithmetic pulse model
        for (int i = 0; i < 8; i++) begin
            cy = $urandom_range(9999, 0); cm = $urandom_range(12, 1); cd = $urandom_range(mdays(cm, cy), 1);
            ty = $urandom_range(9999, 0); tm = $urandom_range(12, 1); td = $urandom_range(mdays(tm, ty), 1);
            load_check($sformatf("rand%0d", i), cy, cm, cd, ty, tm, td, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/date_loader.md
# date_loader

Sequential loader that drives the `up`/`set` editing interface of the calendar date counter until its packed `date_count` equals a requested target date. It replaces manual key-stepping with an automatic writer. It sits beside the date counter, consumes its `date_count` as feedback, and owns its `up[5:0]` and `set[1:0]` inputs while busy.

## Interface
Parameters:
- SETTLE, 2: cycles waited after each `up` pulse (and after asserting `set`) before `date_count` is re-sampled; must be ≥1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- target_year  in  14  binary year, 0..9999.
- target_month  in  4  1..12.
- target_day  in  5  1..last day of target month.
- date_count  in  23  feedback from the date counter: {year[13:0], month[3:0], day[4:0]}.
- up  out  6  increment pulses to the date counter: [0] day, [1] month, [2] year ones digit, [3] tens, [4] hundreds, [5] thousands.
- set  out  2  edit-mode enable to the date counter; 2'b11 while loading, else 2'b00.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse: target reached.
- error  out  1  one-cycle pulse: invalid target or field failed to converge.

## Operation
- Counter contract on `up`:
  - Day: +1, last day → 1.
  - Month: +1, 12 → 1.
  - Each year digit: +1 mod 10, no carry into other digits.
  - Each `up` pulse is exactly 1 cycle wide.
- States:
  - IDLE → CHECK on `start`. `start` is ignored in every other state.
  - CHECK: validate the latched target.
    - Month outside 1..12, day outside 1..last_day, or year > 9999 → ERROR.
    - Otherwise → SETUP.
  - last_day: 31/30 per month; Feb = 29 if leap, else 28. Leap year = (y%4==0 && y%100!=0) || y%400==0.
  - SETUP: drive `set`=2'b11, wait SETTLE cycles, field index = 0 → CMP.
  - CMP: compare the current field of `date_count` against the target.
    - Field order: thousands, hundreds, tens, ones, month, day. Day is last because its range depends on month and year.
    - Equal: advance the field index, reset the pulse counter, stay in CMP next cycle. After the day field → FINISH.
    - Pulse counter = limit (10 per year digit, 12 month, 31 day) → ERROR.
    - Else → PULSE.
  - PULSE: `up[bit]`=1 for 1 cycle, pulse counter +1 → WAIT.
  - WAIT: SETTLE cycles → CMP.
  - FINISH: `done`=1 for 1 cycle, `set`=0 → IDLE.
  - ERROR: `error`=1 for 1 cycle, `set`=0 → IDLE.
- Year digits:
  - Derived combinationally from the binary year (target latched, current from `date_count`) by binary-to-BCD conversion.
  - Targets latched on start; later changes to target inputs are ignored until the next start.
- Pulse counter is 5 bits.

## Timing
- Reset values: `up`=0, `set`=0, `busy`=0, `done`=0, `error`=0, state IDLE, latches 0.
- Reset asserted mid-operation: next cycle all outputs are at reset values. No `up` pulse is truncated or extended beyond that edge.
- Accepted start (start=1 in IDLE at edge 0):
  - `busy`=1 from edge 1.
  - Invalid target: `error`=1 in cycle 2, `busy`=0 in that same cycle.
- Valid target, current date already equal: `set`=2'b11 from edge 2. `done` occurs SETTLE+8 cycles after start: CHECK 1, SETUP SETTLE, CMP 6, FINISH 1.
- Each mismatching step costs 2+SETTLE cycles (PULSE, WAIT×SETTLE, CMP).
- `done` and `error` are never high together. `busy`=0 in the done/error cycle.
- `up` is one-hot or zero in every cycle, and nonzero only in PULSE.

## Test plan
- Reset: hold reset 3 cycles during a load with up[1]=1 → cycle after release, all outputs 0 and state IDLE; start then behaves normally.
- Simple load: counter at 2024-01-01, target 2025-03-15, SETTLE=2, behavioural counter model → `done` once; exactly 1 up[2], 2 up[1] and 14 up[0] pulses; `date_count` = {2025,3,15}.
- Digit wrap: counter 2029-12-31, target 2031-01-01 → up[3]=1 pulse, up[2]=2 pulses (9→0→1), up[1]=1, up[0]=1; `done`.
- Leap validation: target 2023-02-29 → `error` at cycle 2, no `up` or `set` activity. Target 2000-02-29 → `done`. Target 1900-02-29 → `error`.
- Non-convergence: counter model ignores up[1] and starts at month 5, target month 6 → exactly 12 up[1] pulses, then `error`, `set` returns to 0.
- Start while busy: second `start` mid-load with a different target → ignored; final `date_count` equals the first target.
